dmem_unit: RTL and testbench
============================

DMEM_UNIT -- requirements
Module: dmem_unit

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 128, giving the number of 32-bit words of storage (power of two, 16..1024).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port mem_w, input, 1, store request from the CPU MEM stage.
REQ-005 The block SHALL have port Addr_in, input, 32, byte address (CPU ALU result).
REQ-006 The block SHALL have port Data_in, input, 32, store data; only the low bytes are used for sub-word stores.
REQ-007 The block SHALL have port dm_ctrl, input, 3, access size and sign: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned.
REQ-008 The block SHALL have port err_clr, input, 1, synchronous clear of the error flag.
REQ-009 The block SHALL have port Data_out, output, 32, load data, already extended.
REQ-010 The block SHALL have port err, output, 1, sticky flag for a misaligned or out-of-range access.
REQ-011 The block SHALL have port err_addr, output, 32, Addr_in of the first access that set err.
REQ-012 The block SHALL have port store_cnt, output, 16, count of committed stores.

Function
REQ-013 Word index SHALL be Addr_in[log2(DEPTH_WORDS)+1:2]; an access is out-of-range when Addr_in >= DEPTH_WORDS*4.
REQ-014 An access SHALL be misaligned when it is a word access with Addr_in[1:0]!=0, or a half access with Addr_in[0]!=0.
REQ-015 An access is valid only when it is in range, aligned, and uses dm_ctrl 000..100.
REQ-016 A valid store (mem_w=1) SHALL commit at the next rising edge, byte-masked as follows: word writes all 4 lanes; half writes lanes {1,0} when Addr_in[1]=0, else {3,2}, from Data_in[15:0]; byte writes lane Addr_in[1:0] from Data_in[7:0].
REQ-017 Unwritten lanes SHALL keep their previous contents.
REQ-018 Loads SHALL be combinational (zero-cycle latency): Data_out follows Addr_in/dm_ctrl within the same cycle, as the CPU samples it into MEM/WB at the next edge.
REQ-019 Load extension: 001/011 sign-extend from bit 15/7; 010/100 zero-extend; 000 passes the full word.
REQ-020 For a misaligned or out-of-range access, Data_out SHALL be 0, and a store SHALL be suppressed (no lane written, store_cnt unchanged).
REQ-021 Read-during-write to the same word: Data_out SHALL show the pre-write contents in the write cycle and the new contents from the following cycle.
REQ-022 Error state machine: state CLEAN (err=0) goes to FAULT (err=1, err_addr<=Addr_in) on an edge where a misaligned or out-of-range access occurs with mem_w=1, or with mem_w=0 and dm_ctrl 000..100.
REQ-023 In FAULT, further faults SHALL NOT update err_addr.
REQ-024 err_clr=1 SHALL move FAULT to CLEAN and leave err_addr unchanged.
REQ-025 A fault and err_clr in the same cycle SHALL leave the block in FAULT, with err_addr taken from the new fault.
REQ-026 dm_ctrl 101..111 SHALL be a no-op: no store, Data_out=0, err unaffected.
REQ-027 store_cnt SHALL increment by 1 per committed store and wrap 0xFFFF->0x0000.

Reset
REQ-028 While rst=0, asynchronously: all memory words=0, err=0, err_addr=0, store_cnt=0; therefore Data_out=0.
REQ-029 A store coincident with reset assertion SHALL be lost; the first edge after rst deasserts SHALL operate normally.

Structure
REQ-030 The dm_ctrl encodings (dm_word, dm_halfword, dm_halfword_unsigned, dm_byte, dm_byte_unsigned) SHALL live in the shared ctrl_encode_def definitions, not locally.
REQ-031 Lane selection, write mask and load extension SHALL be one combinational sub-module, dm_lane; the storage array, error FSM and counter stay in dmem_unit.

Verification
REQ-032 Scenario: word store 0xDEADBEEF @0x10, then half load (001) @0x12 -> Data_out=0xFFFFDEAD; half load unsigned (010) @0x12 -> 0x0000DEAD; store_cnt=1.
REQ-033 Scenario: byte store 0x80 @0x21 over word 0 at 0x20, then word load @0x20 -> 0x00008000; byte load (011) @0x21 -> 0xFFFFFF80.
REQ-034 Scenario: word store @0x06 -> memory unchanged, err=1, err_addr=0x06; then half store @0x03 -> err_addr stays 0x06; err_clr pulse -> err=0.
REQ-035 Scenario: DEPTH_WORDS=128, word load @0x200 -> Data_out=0, err=1; err_clr and a fault @0x204 in the same cycle -> err=1, err_addr=0x204.
REQ-036 Scenario: word store 0x11111111 then 0x22222222 @0x0 on back-to-back cycles, read @0x0 -> Data_out is 0x11111111 in the second write cycle and 0x22222222 after.
REQ-037 Scenario: preset store_cnt to 0xFFFF via 65535 stores, one more store -> store_cnt=0x0000; async rst pulse mid-cycle -> all outputs 0 immediately.

Source files
------------

// File: rtl/ctrl_encode_def.sv
// Shared CPU control encodings; dm_ctrl values select data-memory access size and sign.
package ctrl_encode_def;

  localparam logic [2:0] dm_word              = 3'b000;
  localparam logic [2:0] dm_halfword          = 3'b001;
  localparam logic [2:0] dm_halfword_unsigned = 3'b010;
  localparam logic [2:0] dm_byte              = 3'b011;
  localparam logic [2:0] dm_byte_unsigned     = 3'b100;

endpackage

// File: rtl/dmem_unit_pkg.sv
// Types and helpers local to the data-memory unit.
package dmem_unit_pkg;
  import ctrl_encode_def::*;

  typedef enum logic {
    ERR_CLEAN = 1'b0,
    ERR_FAULT = 1'b1
  } err_state_e;

  // Encodings 101..111 are reserved and behave as a no-op.
  function automatic logic ctrl_is_valid(input logic [2:0] ctrl);
    return ctrl <= dm_byte_unsigned;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// CPU MEM-stage to data-memory bus; the CPU is master, dmem_unit is slave.
interface dmem_if;
  logic        mem_w;
  logic [31:0] Addr_in;
  logic [31:0] Data_in;
  logic [2:0]  dm_ctrl;
  logic        err_clr;
  logic [31:0] Data_out;
  logic        err;
  logic [31:0] err_addr;
  logic [15:0] store_cnt;

  modport master (
    output mem_w, Addr_in, Data_in, dm_ctrl, err_clr,
    input  Data_out, err, err_addr, store_cnt
  );

  modport slave (
    input  mem_w, Addr_in, Data_in, dm_ctrl, err_clr,
    output Data_out, err, err_addr, store_cnt
  );
endinterface

// File: rtl/dmem_unit_lane.sv
// Byte-lane steering: store write mask/replication, alignment check, load extraction and extension.
module dm_lane
  import ctrl_encode_def::*;
  import dmem_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  dm_ctrl,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wlanes,
  output logic [31:0] rdata,
  output logic        aligned,
  output logic        ctrl_ok
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  assign half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
  assign byte_sel = rword[8*addr_lo +: 8];
  assign ctrl_ok  = ctrl_is_valid(dm_ctrl);

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    wmask   = 4'b0000;
    wlanes  = wdata;
    rdata   = '0;
    aligned = 1'b0;
    unique case (dm_ctrl)
      dm_word: begin
        aligned = (addr_lo == 2'b00);
        wmask   = 4'b1111;
        rdata   = rword;
      end
      dm_halfword, dm_halfword_unsigned: begin
        aligned = ~addr_lo[0];
        wmask   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wlanes  = {2{wdata[15:0]}};
        rdata   = (dm_ctrl == dm_halfword) ? {{16{half_sel[15]}}, half_sel}
                                           : {16'h0000, half_sel};
      end
      dm_byte, dm_byte_unsigned: begin
        aligned = 1'b1;
        wmask   = 4'b0001 << addr_lo;
        wlanes  = {4{wdata[7:0]}};
        rdata   = (dm_ctrl == dm_byte) ? {{24{byte_sel[7]}}, byte_sel}
                                       : {24'h000000, byte_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_unit.sv
// Data memory for the CPU MEM stage: byte-addressed store array, combinational loads,
// sticky access-error capture and a committed-store counter.
module dmem_unit
  import dmem_unit_pkg::*;
#(
  parameter int DEPTH_WORDS = 128
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          in_range;
  logic [31:0]   rword;
  logic [3:0]    wmask;
  logic [31:0]   wlanes;
  logic [31:0]   rdata;
  logic          aligned;
  logic          ctrl_ok;
  logic          access_ok;
  logic          fault;
  logic          store_go;

  err_state_e    state;
  logic          err_q;
  logic [31:0]   err_addr_q;
  logic [15:0]   store_cnt_q;

  assign idx      = bus.Addr_in[AW+1:2];
  assign in_range = (bus.Addr_in[31:AW+2] == '0);
  assign rword    = mem[idx];

  dm_lane u_lane (
    .addr_lo (bus.Addr_in[1:0]),
    .dm_ctrl (bus.dm_ctrl),
    .wdata   (bus.Data_in),
    .rword   (rword),
    .wmask   (wmask),
    .wlanes  (wlanes),
    .rdata   (rdata),
    .aligned (aligned),
    .ctrl_ok (ctrl_ok)
  );

  // Reserved encodings never fault; otherwise loads and stores fault alike.
  assign access_ok = ctrl_ok & aligned & in_range;
  assign fault     = ctrl_ok & ~(aligned & in_range);
  assign store_go  = bus.mem_w & access_ok;

  // NOTE: the array is flop-based so it can be cleared asynchronously with the rest of the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (store_go) begin
      for (int l = 0; l < 4; l++)
        if (wmask[l]) mem[idx][8*l +: 8] <= wlanes[8*l +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ERR_CLEAN;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      unique case (state)
        ERR_CLEAN: if (fault) begin
          state      <= ERR_FAULT;
          err_q      <= 1'b1;
          err_addr_q <= bus.Addr_in;
        end
        ERR_FAULT: if (bus.err_clr) begin
          // A fresh fault in the clear cycle re-arms with the new address.
          if (fault) begin
            err_addr_q <= bus.Addr_in;
          end else begin
            state <= ERR_CLEAN;
            err_q <= 1'b0;
          end
        end
        default: begin
          state <= ERR_CLEAN;
          err_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          store_cnt_q <= '0;
    else if (store_go) store_cnt_q <= store_cnt_q + 16'd1;
  end

  assign bus.Data_out  = access_ok ? rdata : '0;
  assign bus.err       = err_q;
  assign bus.err_addr  = err_addr_q;
  assign bus.store_cnt = store_cnt_q;

endmodule

// File: tb/tb_dmem_unit.sv
// Directed bench for dmem_unit: sub-word stores/loads, error capture, counter wrap and reset.
module tb_dmem_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dmem_if bus ();

  dmem_unit #(.DEPTH_WORDS(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] c, input logic clr);
    bus.mem_w   = w;
    bus.Addr_in = a;
    bus.Data_in = d;
    bus.dm_ctrl = c;
    bus.err_clr = clr;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 3'b101, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
    check("reset_data_out", bus.Data_out, 32'h0);
    check("reset_err", {31'b0, bus.err}, 32'h0);
    check("reset_err_addr", bus.err_addr, 32'h0);
    check("reset_store_cnt", {16'b0, bus.store_cnt}, 32'h0);
    idle();
    #10 rst = 1'b1;
    tick();

    // Word store then half loads.
    drive(1'b1, 32'h10, 32'hDEADBEEF, 3'b000, 1'b0);
    check("rdw_pre_write", bus.Data_out, 32'h0);
    tick();
    drive(1'b0, 32'h12, 32'h0, 3'b001, 1'b0);
    check("half_signed_hi", bus.Data_out, 32'hFFFFDEAD);
    drive(1'b0, 32'h12, 32'h0, 3'b010, 1'b0);
    check("half_unsigned_hi", bus.Data_out, 32'h0000DEAD);
    drive(1'b0, 32'h10, 32'h0, 3'b001, 1'b0);
    check("half_signed_lo", bus.Data_out, 32'hFFFFBEEF);
    drive(1'b0, 32'h13, 32'h0, 3'b011, 1'b0);
    check("byte_lane3", bus.Data_out, 32'hFFFFFFDE);
    check("store_cnt_1", {16'b0, bus.store_cnt}, 32'd1);

    // Byte store into a zeroed word.
    drive(1'b1, 32'h20, 32'h0, 3'b000, 1'b0);
    tick();
    drive(1'b1, 32'h21, 32'hFFFFFF80, 3'b011, 1'b0);
    tick();
    drive(1'b0, 32'h20, 32'h0, 3'b000, 1'b0);
    check("byte_store_word", bus.Data_out, 32'h00008000);
    drive(1'b0, 32'h21, 32'h0, 3'b011, 1'b0);
    check("byte_load_signed", bus.Data_out, 32'hFFFFFF80);
    drive(1'b0, 32'h21, 32'h0, 3'b100, 1'b0);
    check("byte_load_unsigned", bus.Data_out, 32'h00000080);

    // Half store to upper lanes keeps the lower lanes.
    drive(1'b1, 32'h22, 32'hAAAA5555, 3'b001, 1'b0);
    tick();
    drive(1'b0, 32'h20, 32'h0, 3'b000, 1'b0);
    check("half_store_upper", bus.Data_out, 32'h55558000);
    check("store_cnt_4", {16'b0, bus.store_cnt}, 32'd4);

    // Misaligned stores: suppressed, first address captured.
    drive(1'b1, 32'h06, 32'h12345678, 3'b000, 1'b0);
    check("misaligned_data_out", bus.Data_out, 32'h0);
    tick();
    check("misaligned_err", {31'b0, bus.err}, 32'h1);
    check("misaligned_err_addr", bus.err_addr, 32'h6);
    check("misaligned_no_count", {16'b0, bus.store_cnt}, 32'd4);
    drive(1'b0, 32'h04, 32'h0, 3'b000, 1'b0);
    check("misaligned_mem_kept", bus.Data_out, 32'h0);
    drive(1'b1, 32'h03, 32'h0000FFFF, 3'b001, 1'b0);
    tick();
    check("second_fault_addr_kept", bus.err_addr, 32'h6);
    drive(1'b0, 32'h00, 32'h0, 3'b101, 1'b1);
    tick();
    check("err_clr_clears", {31'b0, bus.err}, 32'h0);
    check("err_clr_addr_kept", bus.err_addr, 32'h6);

    // Reserved encoding: no store, zero data, no fault.
    drive(1'b1, 32'h10, 32'h01020304, 3'b111, 1'b0);
    check("noop_data_out", bus.Data_out, 32'h0);
    tick();
    drive(1'b1, 32'h200, 32'h01020304, 3'b110, 1'b0);
    tick();
    check("noop_no_err", {31'b0, bus.err}, 32'h0);
    check("noop_no_count", {16'b0, bus.store_cnt}, 32'd4);
    drive(1'b0, 32'h10, 32'h0, 3'b000, 1'b0);
    check("noop_mem_kept", bus.Data_out, 32'hDEADBEEF);

    // Out-of-range load, then clear racing a new fault.
    drive(1'b0, 32'h200, 32'h0, 3'b000, 1'b0);
    check("oor_data_out", bus.Data_out, 32'h0);
    tick();
    check("oor_err", {31'b0, bus.err}, 32'h1);
    check("oor_err_addr", bus.err_addr, 32'h200);
    drive(1'b0, 32'h204, 32'h0, 3'b000, 1'b1);
    tick();
    check("clr_and_fault_err", {31'b0, bus.err}, 32'h1);
    check("clr_and_fault_addr", bus.err_addr, 32'h204);
    drive(1'b0, 32'h00, 32'h0, 3'b101, 1'b1);
    tick();
    check("final_clr", {31'b0, bus.err}, 32'h0);

    // Back-to-back stores to the same word.
    drive(1'b1, 32'h0, 32'h11111111, 3'b000, 1'b0);
    tick();
    drive(1'b1, 32'h0, 32'h22222222, 3'b000, 1'b0);
    check("b2b_second_cycle", bus.Data_out, 32'h11111111);
    tick();
    drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
    check("b2b_after", bus.Data_out, 32'h22222222);
    check("store_cnt_6", {16'b0, bus.store_cnt}, 32'd6);

    // Counter wrap.
    drive(1'b1, 32'h40, 32'h0, 3'b000, 1'b0);
    repeat (65529) @(posedge clk);
    #1;
    check("store_cnt_ffff", {16'b0, bus.store_cnt}, 32'h0000FFFF);
    tick();
    check("store_cnt_wrap", {16'b0, bus.store_cnt}, 32'h0);

    // Async reset mid-cycle after arming a fault.
    drive(1'b0, 32'h300, 32'h0, 3'b000, 1'b0);
    tick();
    check("pre_reset_err", {31'b0, bus.err}, 32'h1);
    drive(1'b0, 32'h10, 32'h0, 3'b000, 1'b0);
    check("pre_reset_data", bus.Data_out, 32'hDEADBEEF);
    #2 rst = 1'b0;
    #1;
    check("async_rst_data_out", bus.Data_out, 32'h0);
    check("async_rst_err", {31'b0, bus.err}, 32'h0);
    check("async_rst_err_addr", bus.err_addr, 32'h0);
    check("async_rst_store_cnt", {16'b0, bus.store_cnt}, 32'h0);

    // Store during reset is lost; first edge after release works.
    drive(1'b1, 32'h10, 32'h00000005, 3'b000, 1'b0);
    tick();
    #3 rst = 1'b1;
    #1;
    check("store_in_reset_lost", bus.Data_out, 32'h0);
    tick();
    check("post_reset_store", bus.Data_out, 32'h00000005);
    check("post_reset_count", {16'b0, bus.store_cnt}, 32'd1);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
